// File: rtl/mem_port_arbiter.sv
// Two-port arbiter (CPU + DMA/debug loader) in front of a single unified memory.
// Round-robin on contention; define ARB_FIXED_PRIO_EN to give the CPU strict priority.
module mem_port_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int MEM_LAT = 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_gnt,
    output logic          cpu_rvalid,
    output logic [DW-1:0] cpu_rdata,
    input  logic          dma_req,
    input  logic          dma_we,
    input  logic [AW-1:0] dma_addr,
    input  logic [DW-1:0] dma_wdata,
    output logic          dma_gnt,
    output logic          dma_rvalid,
    output logic [DW-1:0] dma_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy,
    output logic [0:0]    dbg_state
);

    // Handshake: a requester holds req (and its we/addr/wdata) until gnt is
    // seen high in the same cycle; gnt and rvalid are single-cycle pulses.

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_WAIT = 1'b1;
    localparam logic       OWN_CPU = 1'b0;
    localparam logic       OWN_DMA = 1'b1;
    // MEM_LAT must lie in 1..7: cnt counts it down to 1 in a 3-bit register.
    localparam logic [2:0] LAT = 3'(MEM_LAT);

    logic [0:0]    state;
    logic [2:0]    cnt;
    logic          owner;
    logic          last_winner;
    logic [DW-1:0] cpu_rdata_q;
    logic [DW-1:0] dma_rdata_q;

    logic          pick_dma;
    logic          grant_any;
    logic          we_sel;
    logic          rd_done;

    always_comb begin
        pick_dma = 1'b0;
`ifdef ARB_FIXED_PRIO_EN
        pick_dma = dma_req && !cpu_req;
`else
        pick_dma = dma_req && (!cpu_req || (last_winner == OWN_CPU));
`endif
        grant_any = !reset && (state == S_IDLE) && (cpu_req || dma_req);
        we_sel    = pick_dma ? dma_we : cpu_we;

        cpu_gnt   = grant_any && !pick_dma;
        dma_gnt   = grant_any && pick_dma;
        mem_en    = grant_any;
        mem_we    = grant_any && we_sel;
        mem_addr  = '0;
        mem_wdata = '0;
        if (grant_any) begin
            mem_addr  = pick_dma ? dma_addr  : cpu_addr;
            mem_wdata = pick_dma ? dma_wdata : cpu_wdata;
        end

        rd_done    = !reset && (state == S_WAIT) && (cnt == 3'd1);
        cpu_rvalid = rd_done && (owner == OWN_CPU);
        dma_rvalid = rd_done && (owner == OWN_DMA);
        cpu_rdata  = cpu_rvalid ? mem_rdata : cpu_rdata_q;
        dma_rdata  = dma_rvalid ? mem_rdata : dma_rdata_q;
    end

    assign busy      = (state == S_WAIT);
    assign dbg_state = state;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            cnt         <= 3'd0;
            owner       <= OWN_CPU;
            last_winner <= OWN_DMA;
            cpu_rdata_q <= '0;
            dma_rdata_q <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (grant_any) begin
                        last_winner <= pick_dma;
                        if (!we_sel) begin
                            owner <= pick_dma;
                            cnt   <= LAT;
                            state <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    cnt <= cnt - 3'd1;
                    if (cnt == 3'd1) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
            if (cpu_rvalid) cpu_rdata_q <= mem_rdata;
            if (dma_rvalid) dma_rdata_q <= mem_rdata;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: one instance at MEM_LAT=1, one at MEM_LAT=3,
// both fed from the same requester and memory-data stimulus.
module tb_mem_port_arbiter;

    logic        clk;
    logic        reset;
    logic        cpu_req, cpu_we, dma_req, dma_we;
    logic [31:0] cpu_addr, cpu_wdata, dma_addr, dma_wdata, mem_rdata;

    logic        o1_cpu_gnt, o1_cpu_rvalid, o1_dma_gnt, o1_dma_rvalid, o1_mem_en, o1_mem_we, o1_busy;
    logic [31:0] o1_cpu_rdata, o1_dma_rdata, o1_mem_addr, o1_mem_wdata;
    logic [0:0]  o1_state;
    logic        o3_cpu_gnt, o3_cpu_rvalid, o3_dma_gnt, o3_dma_rvalid, o3_mem_en, o3_mem_we, o3_busy;
    logic [31:0] o3_cpu_rdata, o3_dma_rdata, o3_mem_addr, o3_mem_wdata;
    logic [0:0]  o3_state;

    int errors = 0;
    int checks = 0;

    mem_port_arbiter #(.AW(32), .DW(32), .MEM_LAT(1)) u_dut1 (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(o1_cpu_gnt), .cpu_rvalid(o1_cpu_rvalid), .cpu_rdata(o1_cpu_rdata),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_gnt(o1_dma_gnt), .dma_rvalid(o1_dma_rvalid), .dma_rdata(o1_dma_rdata),
        .mem_en(o1_mem_en), .mem_we(o1_mem_we), .mem_addr(o1_mem_addr), .mem_wdata(o1_mem_wdata),
        .mem_rdata(mem_rdata), .busy(o1_busy), .dbg_state(o1_state)
    );

    mem_port_arbiter #(.AW(32), .DW(32), .MEM_LAT(3)) u_dut3 (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(o3_cpu_gnt), .cpu_rvalid(o3_cpu_rvalid), .cpu_rdata(o3_cpu_rdata),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_gnt(o3_dma_gnt), .dma_rvalid(o3_dma_rvalid), .dma_rdata(o3_dma_rdata),
        .mem_en(o3_mem_en), .mem_we(o3_mem_we), .mem_addr(o3_mem_addr), .mem_wdata(o3_mem_wdata),
        .mem_rdata(mem_rdata), .busy(o3_busy), .dbg_state(o3_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle_inputs();
        cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
        dma_req = 0; dma_we = 0; dma_addr = 0; dma_wdata = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        idle_inputs();
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b1;
        cpu_req = 1; dma_req = 1; cpu_addr = 32'h55; dma_addr = 32'h66;
        #1;
        checks++;
        if ({o1_cpu_gnt, o1_dma_gnt, o1_mem_en, o1_mem_we, o1_busy, o1_cpu_rvalid, o1_dma_rvalid} !== 7'b0) begin
            errors++; $display("FAIL rst_ctrl got=%b exp=0", {o1_cpu_gnt, o1_dma_gnt, o1_mem_en, o1_mem_we, o1_busy, o1_cpu_rvalid, o1_dma_rvalid});
        end
        checks++;
        if ({o1_mem_addr, o1_cpu_rdata, o1_dma_rdata} !== 96'h0) begin
            errors++; $display("FAIL rst_data got=%h exp=0", {o1_mem_addr, o1_cpu_rdata, o1_dma_rdata});
        end
        checks++;
        if (o3_state !== 1'b0) begin
            errors++; $display("FAIL rst_state got=%0d exp=0", o3_state);
        end
        @(negedge clk);
        reset = 1'b0;
        idle_inputs();
    endtask

    task automatic test_read_lat1();
        do_reset();
        @(negedge clk);
        cpu_req = 1; cpu_we = 0; cpu_addr = 32'h10;
        #1;
        checks++;
        if ({o1_cpu_gnt, o1_dma_gnt, o1_mem_en, o1_mem_we} !== 4'b1010) begin
            errors++; $display("FAIL rd1_grant got=%b exp=1010", {o1_cpu_gnt, o1_dma_gnt, o1_mem_en, o1_mem_we});
        end
        checks++;
        if (o1_mem_addr !== 32'h10) begin
            errors++; $display("FAIL rd1_addr got=%h exp=00000010", o1_mem_addr);
        end
        @(negedge clk);
        cpu_addr = 32'h20; cpu_we = 1; cpu_wdata = 32'hA5A5_0001;
        mem_rdata = 32'hDEAD_BEEF;
        #1;
        checks++;
        if ({o1_cpu_rvalid, o1_dma_rvalid, o1_busy, o1_cpu_gnt, o1_mem_en} !== 5'b10100) begin
            errors++; $display("FAIL rd1_wait got=%b exp=10100", {o1_cpu_rvalid, o1_dma_rvalid, o1_busy, o1_cpu_gnt, o1_mem_en});
        end
        checks++;
        if (o1_cpu_rdata !== 32'hDEAD_BEEF) begin
            errors++; $display("FAIL rd1_data got=%h exp=deadbeef", o1_cpu_rdata);
        end
        @(negedge clk);
        mem_rdata = 32'h1111_2222;
        #1;
        checks++;
        if ({o1_cpu_gnt, o1_mem_we, o1_busy, o1_cpu_rvalid} !== 4'b1100) begin
            errors++; $display("FAIL rd1_next_gnt got=%b exp=1100", {o1_cpu_gnt, o1_mem_we, o1_busy, o1_cpu_rvalid});
        end
        checks++;
        if (o1_cpu_rdata !== 32'hDEAD_BEEF) begin
            errors++; $display("FAIL rd1_hold got=%h exp=deadbeef", o1_cpu_rdata);
        end
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic test_back_to_back();
        logic exp_cpu;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            cpu_req = 1; cpu_we = 1; cpu_addr = 32'h0;   cpu_wdata = 32'hC000_0000 + i;
            dma_req = 1; dma_we = 1; dma_addr = 32'h100; dma_wdata = 32'hD000_0000 + i;
`ifdef ARB_FIXED_PRIO_EN
            exp_cpu = 1'b1;
`else
            exp_cpu = (i % 2 == 0);
`endif
            #1;
            checks++;
            if ({o1_cpu_gnt, o1_dma_gnt, o1_mem_en, o1_mem_we} !== {exp_cpu, !exp_cpu, 2'b11}) begin
                errors++; $display("FAIL b2b_gnt[%0d] got=%b exp=%b", i, {o1_cpu_gnt, o1_dma_gnt, o1_mem_en, o1_mem_we}, {exp_cpu, !exp_cpu, 2'b11});
            end
            checks++;
            if (o1_mem_addr !== (exp_cpu ? 32'h0 : 32'h100) || o1_mem_wdata !== (exp_cpu ? 32'hC000_0000 + i : 32'hD000_0000 + i)) begin
                errors++; $display("FAIL b2b_bus[%0d] got=%h/%h", i, o1_mem_addr, o1_mem_wdata);
            end
        end
        @(negedge clk);
        cpu_req = 0;
        #1;
        checks++;
        if ({o1_cpu_gnt, o1_dma_gnt, o1_mem_addr} !== {2'b01, 32'h100}) begin
            errors++; $display("FAIL b2b_cpu_drop got=%b/%h exp=01/00000100", {o1_cpu_gnt, o1_dma_gnt}, o1_mem_addr);
        end
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic test_dma_read_lat3();
        do_reset();
        @(negedge clk);
        dma_req = 1; dma_we = 0; dma_addr = 32'h200;
        #1;
        checks++;
        if ({o3_dma_gnt, o3_cpu_gnt, o3_mem_en, o3_mem_we, o3_mem_addr} !== {4'b1010, 32'h200}) begin
            errors++; $display("FAIL dr3_grant got=%b/%h", {o3_dma_gnt, o3_cpu_gnt, o3_mem_en, o3_mem_we}, o3_mem_addr);
        end
        @(negedge clk);
        dma_req = 0; cpu_req = 1; cpu_we = 0; cpu_addr = 32'h44;
        #1;
        checks++;
        if ({o3_cpu_gnt, o3_dma_rvalid, o3_busy, o3_mem_en} !== 4'b0010) begin
            errors++; $display("FAIL dr3_t1 got=%b exp=0010", {o3_cpu_gnt, o3_dma_rvalid, o3_busy, o3_mem_en});
        end
        @(negedge clk);
        #1;
        checks++;
        if ({o3_cpu_gnt, o3_dma_rvalid, o3_cpu_rvalid} !== 3'b000) begin
            errors++; $display("FAIL dr3_t2 got=%b exp=000", {o3_cpu_gnt, o3_dma_rvalid, o3_cpu_rvalid});
        end
        @(negedge clk);
        mem_rdata = 32'h1234_5678;
        #1;
        checks++;
        if ({o3_dma_rvalid, o3_cpu_rvalid, o3_cpu_gnt, o3_dma_rdata} !== {3'b100, 32'h1234_5678}) begin
            errors++; $display("FAIL dr3_t3 got=%b/%h exp=100/12345678", {o3_dma_rvalid, o3_cpu_rvalid, o3_cpu_gnt}, o3_dma_rdata);
        end
        @(negedge clk);
        mem_rdata = 32'h0;
        #1;
        checks++;
        if ({o3_cpu_gnt, o3_dma_gnt, o3_busy, o3_mem_addr} !== {3'b100, 32'h44}) begin
            errors++; $display("FAIL dr3_cpu_gnt got=%b/%h exp=100/00000044", {o3_cpu_gnt, o3_dma_gnt, o3_busy}, o3_mem_addr);
        end
        @(negedge clk);
        cpu_req = 0;
        @(negedge clk);
        @(negedge clk);
        mem_rdata = 32'hCAFE_F00D;
        #1;
        checks++;
        if ({o3_cpu_rvalid, o3_dma_rvalid, o3_cpu_rdata, o3_dma_rdata} !== {2'b10, 32'hCAFE_F00D, 32'h1234_5678}) begin
            errors++; $display("FAIL dr3_cpu_rd got=%b/%h/%h", {o3_cpu_rvalid, o3_dma_rvalid}, o3_cpu_rdata, o3_dma_rdata);
        end
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic test_reset_during_wait();
        do_reset();
        @(negedge clk);
        cpu_req = 1; cpu_we = 0; cpu_addr = 32'hFFFF_FFFF;
        #1;
        checks++;
        if ({o3_cpu_gnt, o3_mem_addr} !== {1'b1, 32'hFFFF_FFFF}) begin
            errors++; $display("FAIL rw_grant got=%b/%h", o3_cpu_gnt, o3_mem_addr);
        end
        @(negedge clk);
        cpu_req = 0;
        mem_rdata = 32'hBAD0_BAD0;
        reset = 1'b1;
        #1;
        checks++;
        if ({o3_busy, o3_state, o3_cpu_rvalid, o3_mem_en, o3_cpu_rdata} !== {4'b0000, 32'h0}) begin
            errors++; $display("FAIL rw_abort got=%b/%h exp=0000/0", {o3_busy, o3_state, o3_cpu_rvalid, o3_mem_en}, o3_cpu_rdata);
        end
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if ({o3_cpu_rvalid, o3_dma_rvalid, o3_busy} !== 3'b000) begin
                errors++; $display("FAIL rw_no_rvalid[%0d] got=%b exp=000", i, {o3_cpu_rvalid, o3_dma_rvalid, o3_busy});
            end
            @(negedge clk);
        end
        cpu_req = 1; cpu_we = 1; dma_req = 1; dma_we = 1;
        #1;
        checks++;
        if ({o3_cpu_gnt, o3_dma_gnt} !== 2'b10) begin
            errors++; $display("FAIL rw_tie got=%b exp=10", {o3_cpu_gnt, o3_dma_gnt});
        end
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic test_drop_req();
        logic [1:0] exp_tie;
        do_reset();
        @(negedge clk);
        cpu_req = 1; cpu_we = 0; cpu_addr = 32'h300;
        #1;
        checks++;
        if (o3_cpu_gnt !== 1'b1) begin
            errors++; $display("FAIL dq_grant got=%b exp=1", o3_cpu_gnt);
        end
        @(negedge clk);
        cpu_req = 0; dma_req = 1; dma_we = 1; dma_addr = 32'h400;
        #1;
        checks++;
        if ({o3_dma_gnt, o3_mem_en} !== 2'b00) begin
            errors++; $display("FAIL dq_pulse got=%b exp=00", {o3_dma_gnt, o3_mem_en});
        end
        @(negedge clk);
        dma_req = 0;
        @(negedge clk);
        @(negedge clk);
        cpu_req = 1; cpu_we = 1; dma_req = 1; dma_we = 1;
`ifdef ARB_FIXED_PRIO_EN
        exp_tie = 2'b10;
`else
        exp_tie = 2'b01;
`endif
        #1;
        checks++;
        if ({o3_cpu_gnt, o3_dma_gnt} !== exp_tie) begin
            errors++; $display("FAIL dq_tie got=%b exp=%b", {o3_cpu_gnt, o3_dma_gnt}, exp_tie);
        end
        @(negedge clk);
        idle_inputs();
    endtask

    initial begin
        reset = 1'b1;
        mem_rdata = 32'h0;
        idle_inputs();
        test_reset();
        test_read_lat1();
        test_back_to_back();
        test_dma_read_lat3();
        test_reset_during_wait();
        test_drop_req();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single unified instruction/data memory between two requesters: the multicycle CPU memory interface and a DMA/debug loader port.
- Sits between both requesters and the memory array.
- Provides a request/grant handshake, one outstanding transaction at a time, fixed-latency read return, and round-robin arbitration on contention.

Parameters:
- AW, 32, address width in bits.
- DW, 32, data width in bits.
- MEM_LAT, 1, memory read latency in cycles from the mem_en cycle to the mem_rdata-valid cycle; legal range 1..7.

Ports:
- clk  input  1  clock.
- reset  input  1  asynchronous, active-high reset.
- cpu_req  input  1  CPU request; held high until cpu_gnt.
- cpu_we  input  1  CPU write (1) / read (0).
- cpu_addr  input  AW  CPU address.
- cpu_wdata  input  DW  CPU write data.
- cpu_gnt  output  1  one-cycle pulse: CPU request accepted.
- cpu_rvalid  output  1  one-cycle pulse: cpu_rdata valid.
- cpu_rdata  output  DW  CPU read data.
- dma_req, dma_we, dma_addr, dma_wdata  inputs  1/1/AW/DW  DMA request, same semantics as the CPU inputs.
- dma_gnt, dma_rvalid, dma_rdata  outputs  1/1/DW  DMA grant, read-valid and read data.
- mem_en  output  1  memory access strobe.
- mem_we  output  1  memory write enable.
- mem_addr  output  AW  memory address.
- mem_wdata  output  DW  memory write data.
- mem_rdata  input  DW  memory read data, valid MEM_LAT cycles after mem_en.
- busy  output  1  high while a read is outstanding (state WAIT).

Behaviour:
- States:
  - IDLE: may grant.
  - WAIT: read outstanding; cycle counter cnt (3 bits).
- Reset (async):
  - state=IDLE, cnt=0, owner=CPU, last_winner=DMA, so the CPU wins the first tie.
  - All outputs 0. gnt, mem_en and rvalid are forced low while reset is high.
- IDLE, no req: mem_en=0, stay in IDLE.
- IDLE, one req: grant that requester in the same cycle (combinational gnt).
  - mem_en=1; mem_we/addr/wdata are muxed from the winner.
  - Winner recorded in last_winner.
- IDLE, both req: winner is the requester that is not last_winner (round-robin). The loser keeps req high and is served at the next IDLE cycle.
- Write grant: single-cycle transaction; stay in IDLE. Back-to-back writes are legal every cycle, alternating on contention.
- Read grant: owner latched; go to WAIT with cnt=MEM_LAT.
- WAIT:
  - cnt decrements each cycle; no grants; mem_en=0.
  - In the cycle where cnt==1: the owner's rvalid=1 and its rdata=mem_rdata, then next state=IDLE.
  - Read occupancy is MEM_LAT+1 cycles from grant to the next possible grant.
- Non-owner rdata holds its last value; rvalid goes only to the owner.
- A req dropped before gnt is legal: no side effect, and last_winner is unchanged.
- Requester inputs are sampled only in the grant cycle; changes afterwards do not affect the transaction.
- Reset during WAIT: the transaction is aborted, no rvalid is issued, and the state returns to IDLE.
- Reads and writes at any address, including all-ones, pass through unmodified; there is no address decoding.

Optional Feature:
- Macro ARB_FIXED_PRIO_EN.
- Defined: CPU strictly wins on contention. last_winner is still tracked but ignored; DMA is served only in IDLE cycles with cpu_req low.
- Undefined: round-robin as above.

Test Plan:
- After reset, cpu_req read addr 0x10, MEM_LAT=1, memory holds 0xDEADBEEF -> cpu_gnt at T, mem_en=1, mem_addr=0x10 at T; cpu_rvalid=1 with cpu_rdata=0xDEADBEEF at T+1; busy=1 at T+1; next grant possible at T+2.
- cpu_req and dma_req both write every cycle for 4 cycles (CPU addr 0x0, DMA addr 0x100) -> grants alternate CPU, DMA, CPU, DMA; one mem_en/mem_we per cycle, each with the correct address and data.
- dma_req read while CPU idle, MEM_LAT=3 -> dma_gnt at T; dma_rvalid only at T+3; cpu_rvalid stays 0; a cpu_req raised at T+1 is granted at T+4.
- reset asserted at T+1 of a MEM_LAT=3 read -> all outputs 0 immediately; no rvalid ever issued; state IDLE; next simultaneous req grants the CPU.
- ARB_FIXED_PRIO_EN defined, both req held for 3 write cycles -> cpu_gnt all 3 cycles, dma_gnt 0; CPU drops req -> DMA granted the next cycle.
- dma_req pulsed for 1 cycle while a CPU read is in WAIT -> no dma_gnt; last_winner unchanged; the following CPU/DMA tie is resolved per the round-robin rule.
